// File: rtl/dft_pkg.sv
// Shared widths, complex types and the twiddle generator
// used by the radix-2 butterfly pipeline.
package dft_pkg;

  localparam int  HALF = 8;
  localparam int  TW_W = 8;
  localparam real PI   = 3.14159265358979323846;

  function automatic int idx_w(input int n);
    return (n >= 4) ? $clog2(n / 2) : 1;
  endfunction

  localparam int KW = idx_w(8);

  typedef struct packed {
    logic signed [HALF-1:0] re;
    logic signed [HALF-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } tw_t;

  // Taylor series; angles never exceed pi here
  function automatic real trig(input real x, input bit sine);
    real term;
    real sum;
    term = sine ? x : 1.0;
    sum  = term;
    for (int i = 1; i < 24; i++) begin
      int m;
      m    = sine ? 2 * i + 1 : 2 * i;
      term = -term * x * x / real'(m * (m - 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int tw_comp(
    input int k,
    input int n,
    input int tw,
    input bit im
  );
    real ang;
    real v;
    real sc;
    int  r;
    int  hi;
    int  lo;
    ang = 2.0 * PI * real'(k) / real'(n);
    sc  = real'(1 << (tw - 1));
    v   = im ? -trig(ang, 1'b1) * sc
             :  trig(ang, 1'b0) * sc;
    r   = (v >= 0.0) ? $rtoi(v + 0.5)
                     : -$rtoi(0.5 - v);
    hi  = (1 << (tw - 1)) - 1;
    lo  = -(1 << (tw - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/dft_twiddle_rom.sv
// Synchronous-read twiddle ROM, N_POINTS/2 entries of {wr, wi},
// contents computed at elaboration from dft_pkg::tw_comp.
module dft_twiddle_rom
  import dft_pkg::*;
#(
  parameter int N_POINTS = 8,
  parameter int TW_SZ    = 8,
  parameter int KW_P     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [KW_P-1:0]      k_i,
  output logic [2*TW_SZ-1:0]   w_o
);

  localparam int DEPTH = N_POINTS / 2;

  logic [2*TW_SZ-1:0] rom [DEPTH];
  logic [2*TW_SZ-1:0] w_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam int WR = tw_comp(g, N_POINTS, TW_SZ, 1'b0);
    localparam int WI = tw_comp(g, N_POINTS, TW_SZ, 1'b1);
    assign rom[g] = {WR[TW_SZ-1:0], WI[TW_SZ-1:0]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_q <= '0;
    end else if (en_i) begin
      w_q <= rom[k_i];
    end
  end

  assign w_o = w_q;

endmodule

// File: rtl/dft_butterfly_pipe.sv
// 3-stage radix-2 DIT butterfly: out1=(a+W*b)/2, out2=(a-W*b)/2.
// Define DFT_BFLY_SAT_EN to clamp the final reduction and report o_sat.
module dft_butterfly_pipe
  import dft_pkg::*;
#(
  parameter int WORD_SZ  = 16,
  parameter int TW_SZ    = 8,
  parameter int N_POINTS = 8
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_SZ-1:0]         in_a,
  input  logic [WORD_SZ-1:0]         in_b,
  input  logic [idx_w(N_POINTS)-1:0] in_k,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_SZ-1:0]         out1,
  output logic [WORD_SZ-1:0]         out2,
  output logic                       o_sat
);

  localparam int H  = WORD_SZ / 2;
  localparam int PW = H + TW_SZ;

  logic                 en;
  logic                 v1_q, v2_q, ov_q, sat_q;
  logic [WORD_SZ-1:0]   a1_q, b1_q, a2_q;
  logic [WORD_SZ-1:0]   o1_q, o2_q, o1_d, o2_d;
  logic [2*TW_SZ-1:0]   w1;
  logic signed [H-1:0]  br, bi, ar, ai;
  logic signed [TW_SZ-1:0] wr, wi;
  logic signed [PW-1:0] prr_d, pii_d, pri_d, pir_d;
  logic signed [PW-1:0] prr_q, pii_q, pri_q, pir_q;
  logic signed [PW:0]   tr, ti;
  logic signed [H:0]    wbr, wbi;
  logic signed [H+1:0]  s [4];
  logic [H-1:0]         r [4];
  logic [3:0]           clip;
  logic                 sat_d;
  logic                 unused;

  // one global enable: a held output freezes every stage
  assign en       = !(ov_q && !out_ready);
  assign in_ready = en;

  dft_twiddle_rom #(
    .N_POINTS (N_POINTS),
    .TW_SZ    (TW_SZ),
    .KW_P     (idx_w(N_POINTS))
  ) u_rom (
    .clk_i  (i_CLK),
    .rst_ni (i_RESET),
    .en_i   (en),
    .k_i    (in_k),
    .w_o    (w1)
  );

  assign br = b1_q[WORD_SZ-1:H];
  assign bi = b1_q[H-1:0];
  assign wr = w1[2*TW_SZ-1:TW_SZ];
  assign wi = w1[TW_SZ-1:0];

  assign prr_d = PW'(br) * PW'(wr);
  assign pii_d = PW'(bi) * PW'(wi);
  assign pri_d = PW'(br) * PW'(wi);
  assign pir_d = PW'(bi) * PW'(wr);

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      v2_q  <= 1'b0;
      a2_q  <= '0;
      prr_q <= '0;
      pii_q <= '0;
      pri_q <= '0;
      pir_q <= '0;
    end else if (en) begin
      v1_q  <= in_valid;
      a1_q  <= in_a;
      b1_q  <= in_b;
      v2_q  <= v1_q;
      a2_q  <= a1_q;
      prr_q <= prr_d;
      pii_q <= pii_d;
      pri_q <= pri_d;
      pir_q <= pir_d;
    end
  end

  // slicing at TW_SZ-1 is the arithmetic shift, kept to H+1 bits
  assign tr  = (PW+1)'(prr_q) - (PW+1)'(pii_q);
  assign ti  = (PW+1)'(pri_q) + (PW+1)'(pir_q);
  assign wbr = tr[PW-1:TW_SZ-1];
  assign wbi = ti[PW-1:TW_SZ-1];

  assign ar = a2_q[WORD_SZ-1:H];
  assign ai = a2_q[H-1:0];

  assign s[0] = (H+2)'(ar) + (H+2)'(wbr);
  assign s[1] = (H+2)'(ai) + (H+2)'(wbi);
  assign s[2] = (H+2)'(ar) - (H+2)'(wbr);
  assign s[3] = (H+2)'(ai) - (H+2)'(wbi);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      r[i]    = s[i][H:1];
      clip[i] = 1'b0;
`ifdef DFT_BFLY_SAT_EN
      if (s[i][H+1] != s[i][H]) begin
        clip[i] = 1'b1;
        r[i]    = {s[i][H+1], {(H-1){~s[i][H+1]}}};
      end
`endif
    end
  end

  assign o1_d  = {r[0], r[1]};
  assign o2_d  = {r[2], r[3]};
  assign sat_d = v2_q & (|clip);

  assign unused = ^{tr[PW], tr[TW_SZ-2:0], ti[PW], ti[TW_SZ-2:0],
                    s[0][H+1], s[0][0], s[1][H+1], s[1][0],
                    s[2][H+1], s[2][0], s[3][H+1], s[3][0]};

  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      ov_q  <= 1'b0;
      sat_q <= 1'b0;
      o1_q  <= '0;
      o2_q  <= '0;
    end else if (en) begin
      ov_q  <= v2_q;
      sat_q <= sat_d;
      o1_q  <= o1_d;
      o2_q  <= o2_d;
    end
  end

  assign out_valid = ov_q;
  assign out1      = o1_q;
  assign out2      = o2_q;
  assign o_sat     = sat_q;

endmodule

// File: tb/tb_dft_butterfly_pipe.sv
// Directed + random bench for dft_butterfly_pipe with a
// scoreboard queue fed by an independent integer model.
module tb_dft_butterfly_pipe;

  typedef struct {
    logic [15:0] o1;
    logic [15:0] o2;
    logic        sat;
    int          stamp;
  } exp_t;

  localparam int TW_RE [4] = '{127, 91, 0, -91};
  localparam int TW_IM [4] = '{0, -91, -128, -91};

  logic        clk;
  logic        i_RESET;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [1:0]  in_k;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out1;
  logic [15:0] out2;
  logic        o_sat;

  int   nchk = 0;
  int   nerr = 0;
  int   ndel = 0;
  int   cyc  = 0;
  bit   lat_chk = 1'b1;
  exp_t exp_q[$];

  dft_butterfly_pipe #(
    .WORD_SZ  (16),
    .TW_SZ    (8),
    .N_POINTS (8)
  ) dut (
    .i_CLK     (clk),
    .i_RESET   (i_RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .o_sat     (o_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int wrapn(input int v, input int n);
    int m;
    m = v & ((1 << n) - 1);
    if (m >= (1 << (n - 1))) m = m - (1 << n);
    return m;
  endfunction

  function automatic exp_t mk(input logic [15:0] o1,
                              input logic [15:0] o2, input logic s);
    exp_t e;
    e.o1 = o1;
    e.o2 = o2;
    e.sat = s;
    e.stamp = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic [1:0] k);
    exp_t e;
    int   ar, ai, br, bi, wbr, wbi;
    int   v [4];
    bit   sat;
    ar  = int'($signed(a[15:8]));
    ai  = int'($signed(a[7:0]));
    br  = int'($signed(b[15:8]));
    bi  = int'($signed(b[7:0]));
    wbr = wrapn((br * TW_RE[k] - bi * TW_IM[k]) >>> 7, 9);
    wbi = wrapn((br * TW_IM[k] + bi * TW_RE[k]) >>> 7, 9);
    v[0] = (ar + wbr) >>> 1;
    v[1] = (ai + wbi) >>> 1;
    v[2] = (ar - wbr) >>> 1;
    v[3] = (ai - wbi) >>> 1;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef DFT_BFLY_SAT_EN
      if (v[i] > 127) begin
        v[i] = 127;
        sat = 1'b1;
      end else if (v[i] < -128) begin
        v[i] = -128;
        sat = 1'b1;
      end
`else
      v[i] = wrapn(v[i], 8);
`endif
    end
    e.o1 = {v[0][7:0], v[1][7:0]};
    e.o2 = {v[2][7:0], v[3][7:0]};
    e.sat = sat;
    e.stamp = 0;
    return e;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] k, input bit lit,
                      input exp_t le);
    exp_t e;
    int   g;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_k = k;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 1);
    end else begin
      e = lit ? le : model(a, b, k);
      e.stamp = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 60) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // output-side scoreboard: compare on every transfer
  always @(negedge clk) begin
    exp_t e;
    if (i_RESET && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 0);
      end else begin
        e = exp_q.pop_front();
        chk("out1", 32'(out1), 32'(e.o1));
        chk("out2", 32'(out2), 32'(e.o2));
        chk("o_sat", 32'(o_sat), 32'(e.sat));
        if (lat_chk) chk("latency", cyc, e.stamp + 3);
        ndel++;
      end
    end
  end

  initial begin
    int d0;
    logic [7:0] ext [2];
    ext[0] = 8'h80;
    ext[1] = 8'h7F;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_k = '0;
    out_ready = 1'b1;
    i_RESET = 1'b0;

    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out1", 32'(out1), 0);
    chk("rst_out2", 32'(out2), 0);
    chk("rst_o_sat", 32'(o_sat), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(negedge clk);
    i_RESET = 1'b1;
    @(posedge clk);
    #1;

    send(16'h0A00, 16'h0400, 2'd0, 1'b1,
         mk(16'h0600, 16'h0300, 1'b0));
    drain();
    send(16'h0000, 16'h0400, 2'd2, 1'b1,
         mk(16'h00FE, 16'h0002, 1'b0));
    drain();
`ifdef DFT_BFLY_SAT_EN
    send(16'h8080, 16'h8080, 2'd1, 1'b1,
         mk(16'h80C0, 16'h1BC0, 1'b1));
`else
    send(16'h8080, 16'h8080, 2'd1, 1'b1,
         mk(16'h65C0, 16'h1BC0, 1'b0));
`endif
    drain();

    for (int i = 0; i < 8; i++)
      send(16'($urandom), 16'($urandom),
           2'($urandom_range(0, 3)), 1'b0, mk(0, 0, 0));
    drain();

    for (int i = 0; i < 6; i++)
      send({ext[i % 2], ext[(i / 2) % 2]},
           {ext[(i + 1) % 2], ext[i % 2]},
           2'(i % 4), 1'b0, mk(0, 0, 0));
    drain();

    lat_chk = 1'b0;
    d0 = ndel;
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(16'($urandom), 16'($urandom),
               2'($urandom_range(0, 3)), 1'b0, mk(0, 0, 0));
      end
      begin
        logic [15:0] s1;
        logic [15:0] s2;
        s1 = '0;
        s2 = '0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_valid", 32'(out_valid), 1);
          if (i == 0) begin
            s1 = out1;
            s2 = out2;
          end else begin
            chk("stall_hold1", 32'(out1), 32'(s1));
            chk("stall_hold2", 32'(out2), 32'(s2));
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_delivered", ndel - d0, 5);
    lat_chk = 1'b1;

    send(16'h1234, 16'h5678, 2'd3, 1'b0, mk(0, 0, 0));
    send(16'h8080, 16'h8080, 2'd1, 1'b0, mk(0, 0, 0));
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 1);
    #1 i_RESET = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out1", 32'(out1), 0);
    chk("mid_rst_out2", 32'(out2), 0);
    chk("mid_rst_o_sat", 32'(o_sat), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_RESET = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    d0 = ndel;
    send(16'h0A00, 16'h0400, 2'd0, 1'b1,
         mk(16'h0600, 16'h0300, 1'b0));
    drain();
    chk("post_rst_delivered", ndel - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
